// File: rtl/alu_cc_stage_if.sv
// Execute-stage bus: operand/control inputs from decode and register file,
// registered result, handshake and condition-code outputs back.
interface alu_cc_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [2:0]       ALUK;
  logic             SR2MUX;
  logic [WIDTH-1:0] IR;
  logic [WIDTH-1:0] SR1_IN;
  logic [WIDTH-1:0] SR2_IN;
  logic [WIDTH-1:0] BUS_IN;
  logic             LD_CC;
  logic             LD_BEN;
  logic [WIDTH-1:0] ALU_OUT;
  logic             done;
  logic             busy;
  logic             N;
  logic             Z;
  logic             P;
  logic             BEN;

  modport master (
    output start, ALUK, SR2MUX, IR, SR1_IN, SR2_IN, BUS_IN, LD_CC, LD_BEN,
    input  ALU_OUT, done, busy, N, Z, P, BEN
  );

  modport slave (
    input  start, ALUK, SR2MUX, IR, SR1_IN, SR2_IN, BUS_IN, LD_CC, LD_BEN,
    output ALU_OUT, done, busy, N, Z, P, BEN
  );
endinterface

// File: rtl/alu_cc_stage.sv
// LC-3 execute stage: registered ALU result, N/Z/P condition codes and BEN.
// Optional iterative shift-add multiply (ALUK=100) built when ALU_MUL_EN is defined.
module alu_cc_stage #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MUL_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  alu_cc_stage_if.slave bus
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             done_d, done_q;
  logic             n_d, n_q;
  logic             z_d, z_q;
  logic             p_d, p_q;
  logic             ben_d, ben_q;
  logic             unused_ir;

  assign unused_ir = ^{bus.IR[WIDTH-1:12], bus.IR[8:5]};

  assign op_a = bus.SR1_IN;
  assign op_b = bus.SR2MUX ? {{(WIDTH-5){bus.IR[4]}}, bus.IR[4:0]} : bus.SR2_IN;

  // Any ALUK code not otherwise decoded behaves as PASSA.
  always_comb begin
    alu_res = op_a;
    case (bus.ALUK)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a & op_b;
      3'b010:  alu_res = ~op_a;
      default: alu_res = op_a;
    endcase
  end

  // BEN deliberately samples the pre-edge codes, so a same-edge LD_CC is not seen.
  always_comb begin
    n_d   = n_q;
    z_d   = z_q;
    p_d   = p_q;
    ben_d = ben_q;
    if (bus.LD_CC) begin
      n_d = bus.BUS_IN[WIDTH-1];
      z_d = (bus.BUS_IN == '0);
      p_d = !bus.BUS_IN[WIDTH-1] && (bus.BUS_IN != '0);
    end
    if (bus.LD_BEN) begin
      ben_d = (bus.IR[11] & n_q) | (bus.IR[10] & z_q) | (bus.IR[9] & p_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      done_q    <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      p_q       <= 1'b0;
      ben_q     <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      done_q    <= done_d;
      n_q       <= n_d;
      z_q       <= z_d;
      p_q       <= p_d;
      ben_q     <= ben_d;
    end
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES) + 1;

  state_t           state_d, state_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             is_mul;

  assign is_mul  = (bus.ALUK == 3'b100);
  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    alu_out_d = alu_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_mul) begin
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = MUL;
          end else begin
            alu_out_d = alu_res;
            done_d    = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Final iteration writes the result directly so done lands on this edge.
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          alu_out_d = acc_sum;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
`else
  localparam int unsigned unused_mul_cycles = MUL_CYCLES;

  always_comb begin
    alu_out_d = alu_out_q;
    done_d    = 1'b0;
    if (bus.start) begin
      alu_out_d = alu_res;
      done_d    = 1'b1;
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.ALU_OUT = alu_out_q;
  assign bus.done    = done_q;
  assign bus.N       = n_q;
  assign bus.Z       = z_q;
  assign bus.P       = p_q;
  assign bus.BEN     = ben_q;
endmodule
